// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-in-first-out queue. It decouples a producer from a
// consumer that share one clock domain. Read data is registered. Writes to a
// full FIFO and reads from an empty FIFO are ignored.
//
// Parameters
//   FIFO_WIDTH : bits per data word (>= 1)
//   FIFO_DEPTH : number of storable entries (>= 2, any value)
//
// Ports
//   clk      in   clock; all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   rd_en    in   read request for this cycle
//   data_out out  registered read data
//   wr_en    in   write request for this cycle
//   data_in  in   write data, sampled on the edge that accepts the write
//   full     out  occupancy == FIFO_DEPTH
//   empty    out  occupancy == 0
//
// Handshake: a write is accepted on a rising edge when wr_en is high and the
// FIFO is not full, or when a read is accepted on that same edge. A read is
// accepted on a rising edge when rd_en is high and empty is low. The word
// returned by an accepted read appears on data_out after that edge. full and
// empty come only from the registered occupancy. They never depend on rd_en
// or wr_en in the same cycle.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [FIFO_WIDTH-1:0] data_q,   data_d;

    logic rd_accept;
    logic wr_accept;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A read that is accepted on the same edge frees a slot. So a write to a
    // full FIFO is still accepted when a read is accepted with it.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        data_d   = data_q;

        if (rd_accept) begin
            data_d   = mem[rd_ptr_q];
            // The wrap is an explicit compare, so any depth works.
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    // Reset does not clear storage. The pointers and count define what is
    // valid, so stale words are never read.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//
// Self-checking bench for sync_fifo (FIFO_WIDTH=32, FIFO_DEPTH=8). A queue
// holds the reference contents. The expected data_out, full and empty values
// come from the queue size and the accept rules. Directed steps run first,
// then a randomized phase, and then a reset in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic         wr_en;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         full;
    logic         empty;

    int checks = 0;
    int errors = 0;

    // Reference model: queue contents and the last word read.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_dout;

    sync_fifo #(
        .FIFO_WIDTH(W),
        .FIFO_DEPTH(D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .data_out(data_out),
        .wr_en   (wr_en),
        .data_in (data_in),
        .full    (full),
        .empty   (empty)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".data_out"}, data_out, exp_dout);
        chk({tag, ".empty"}, W'(empty), W'(exp_q.size() == 0));
        chk({tag, ".full"}, W'(full), W'(exp_q.size() == D));
    endtask

    // Drives one clock cycle. The model updates after the edge, and the
    // outputs are checked 1 time unit later.
    task automatic cycle(input logic r, input logic w, input logic [W-1:0] d, input string tag);
        bit m_empty;
        bit m_full;
        bit rd_ok;
        bit wr_ok;
        m_empty = (exp_q.size() == 0);
        m_full  = (exp_q.size() == D);
        rd_ok   = r && !m_empty;
        wr_ok   = w && (!m_full || rd_ok);
        rd_en   = r;
        wr_en   = w;
        data_in = d;
        @(posedge clk);
        #1;
        if (rd_ok) exp_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        rd_en = 1'b0;
        wr_en = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input int n, input string tag);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            rd_en   = 1'($urandom_range(0, 1));
            wr_en   = 1'($urandom_range(0, 1));
            data_in = $urandom;
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        exp_q.delete();
        exp_dout = '0;
        check_state(tag);
    endtask

    initial begin
        rst     = 1'b1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        data_in = '0;
        exp_dout = '0;

        // Reset, then a read while empty.
        do_reset(2, "reset");
        cycle(1'b1, 1'b0, '0, "rd_empty");

        // Basic ordering.
        cycle(1'b0, 1'b1, 32'd10, "wr10");
        cycle(1'b0, 1'b1, 32'd20, "wr20");
        cycle(1'b0, 1'b0, '0, "idle");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, '0, "order_rd");
            if (i == 0) chk("first_read", data_out, 32'd10);
            if (i == 1) chk("second_read", data_out, 32'd20);
        end
        chk("order_hold", data_out, 32'd20);

        // Overflow: 10 writes, the last 2 are dropped.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 32'd3, "ovf_wr");
            if (i == 7) chk("full_after_8", W'(full), W'(1));
        end
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, "ovf_rd");
        chk("ovf_empty", W'(empty), W'(1));
        chk("ovf_hold", data_out, 32'd3);

        // Wrap-around.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, W'(i), "wrap_wr_a");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, "wrap_rd_a");
        for (int i = 8; i < 12; i++) cycle(1'b0, 1'b1, W'(i), "wrap_wr_b");
        chk("wrap_full", W'(full), W'(1));
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, '0, "wrap_rd_b");
            chk("wrap_seq", data_out, W'(i + 4));
        end

        // Simultaneous read and write at count 3.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, W'(100 + i), "sim3_fill");
        cycle(1'b1, 1'b1, 32'd103, "sim3_rw");
        chk("sim3_oldest", data_out, 32'd100);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, W'(104 + i), "simf_fill");
        chk("simf_full", W'(full), W'(1));
        cycle(1'b1, 1'b1, 32'd200, "simf_rw");
        chk("simf_still_full", W'(full), W'(1));
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, "simf_drain");
        chk("simf_last", data_out, 32'd200);

        // Simultaneous read and write while empty: only the write is accepted.
        cycle(1'b1, 1'b1, 32'd300, "sime_rw");
        chk("sime_hold", data_out, 32'd200);
        chk("sime_not_empty", W'(empty), W'(0));
        cycle(1'b1, 1'b0, '0, "sime_rd");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "rand");
        end

        // Reset in the middle of traffic.
        do_reset(1, "pre_mid");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, $urandom, "mid_fill");
        do_reset(1, "mid_reset");
        cycle(1'b0, 1'b1, 32'hA5, "mid_wr");
        cycle(1'b1, 1'b0, '0, "mid_rd");
        chk("mid_a5", data_out, 32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous first-in-first-out buffer with parameterisable data width and depth.
- Used as a general-purpose decoupling queue between producer and consumer logic in the same clock domain.
- Provides registered read data, plus full/empty status for the producer and consumer.
- Overflow writes and underflow reads are safely ignored.

Parameters:
- FIFO_WIDTH, 32, width of each data word in bits (>=1).
- FIFO_DEPTH, 8, number of storable entries (>=2; need not be a power of two).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- rd_en  in  1  read request for the current cycle.
- data_out  out  FIFO_WIDTH  registered read data.
- wr_en  in  1  write request for the current cycle.
- data_in  in  FIFO_WIDTH  write data, sampled on the clock edge when a write is accepted.
- full  out  1  high when the occupancy equals FIFO_DEPTH.
- empty  out  1  high when the occupancy is 0.

Behaviour:
- State:
  - Storage array of FIFO_DEPTH x FIFO_WIDTH.
  - Read pointer and write pointer, each 0..FIFO_DEPTH-1.
  - Occupancy counter, 0..FIFO_DEPTH, of width $clog2(FIFO_DEPTH+1).
- Reset (rst=1 at a rising edge):
  - Pointers and count are set to 0; data_out is set to 0.
  - empty=1 and full=0 after that edge.
  - Storage contents are not cleared.
  - rst has priority over rd_en and wr_en; reset mid-operation discards all stored entries.
- full and empty are decoded combinationally from the registered count only. They are not a function of the current rd_en or wr_en.
- Write acceptance: wr_en && (!full || rd_accept).
  - On acceptance, data_in is written to mem[wr_ptr] and wr_ptr advances.
  - A write while full with no read is dropped silently; state is unchanged.
- Read acceptance: rd_accept = rd_en && !empty.
  - On acceptance, data_out <= mem[rd_ptr] at that edge (data visible 1 cycle after the rd_en edge), and rd_ptr advances.
  - A read while empty is ignored: data_out holds its previous value and the pointers are unchanged.
- Simultaneous read and write:
  - Both accepted when not empty: count is unchanged, and data_out receives the oldest entry, not data_in.
  - When empty: only the write is accepted; there is no write-to-read bypass; count becomes 1.
  - When full: both accepted (the read frees a slot); count stays FIFO_DEPTH.
- Count update: +1 on accepted write only, -1 on accepted read only, otherwise unchanged.
- Pointer wrap: FIFO_DEPTH-1 -> 0, explicitly compared, with no reliance on power-of-two overflow.
- Ordering: data is read in exactly the order it was accepted; no loss, duplication or reordering.
- Status after an accepted write to an empty FIFO: empty deasserts after that same edge. A read may be accepted at the next edge.
- data_out changes only on an accepted read or on reset.

Test Plan:
- Reset: assert rst for 2 edges with random rd_en/wr_en -> data_out=0, empty=1, full=0. Then a read with empty=1 -> data_out stays 0.
- Basic order: write 10 then 20 on consecutive edges, idle 1 cycle, then hold rd_en=1 for 10 cycles.
  - data_out=10 after the first read edge and 20 after the second.
  - empty=1 from then on; data_out holds 20 for the remaining 8 cycles.
- Overflow, DEPTH=8: hold wr_en=1 with data_in=3 for 10 cycles.
  - full=1 after the 8th edge; writes 9 and 10 are dropped.
  - Then 10 reads -> exactly 8 values of 3, then empty=1 and data_out holds 3.
- Wrap-around: write 0..7, read 4, write 8..11, read 8 -> sequence 0..11 in order. Pointers wrap; full/empty correct at each step.
- Simultaneous read/write:
  - At count=3: count stays 3 and the oldest value is output.
  - At full: count stays 8, the new word is stored, and the output order is preserved.
  - At empty with rd_en=wr_en=1: count becomes 1 and data_out is unchanged.
- Reset mid-operation: with 5 entries stored, pulse rst -> empty=1, data_out=0. A subsequent write of 0xA5 followed by a read returns 0xA5.
